uart_tx_queue: RTL and testbench

Transmit-side stage downstream of the pipeline core's output path. Accepts core output commands (1-byte or 4-byte), unpacks words into bytes, and buffers them in a byte FIFO. Serialises the bytes onto txd as 8N1 UART frames. Applies backpressure to the core through output_stall. Runs on the single core clock; there is no separate UART clock domain.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_serializer.sv | 127 ++++++++++++
 rtl/uart_tx_queue.sv | 146 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit queue.
//   - core command encodings accepted from the pipeline core
//   - TX serializer state encoding
//   - UART frame shape constants (8 data bits, 1 stop bit)
//   - small command-decode helper
package uart_pkg;

  localparam logic [1:0] CORE_SIG_BYTE = 2'b10;
  localparam logic [1:0] CORE_SIG_WORD = 2'b11;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_state_e;

  // Both push commands share core_sig[1]; 2'b00/2'b01 are no-ops.
  function automatic logic is_push_cmd(input logic [1:0] sig);
    return sig[1];
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART frame generator.
// Pulls bytes through a valid/ready handshake (pop = byte_valid_i & byte_ready_o)
// and shifts them out LSB first between a low start bit and a high stop bit.
// Ports:
//   clk, rstn       core clock, async active-low reset
//   byte_valid_i    a byte is available from the FIFO
//   byte_data_i     the byte at the FIFO head
//   byte_ready_o    serializer takes the head byte this edge if valid
//   txd_o           registered serial output, idle high
//   busy_o          a frame is in progress
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 1042
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       txd_o,
  output logic       busy_o
);

  localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int TW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(UART_STOP_BITS - 1);

  tx_state_e     state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q;

  logic bit_end_s;
  logic pop_s;

  assign bit_end_s = (timer_q == BIT_LAST);

  // Ready in IDLE, or on the final edge of the last stop bit so that a queued
  // byte starts its start bit with no idle gap.
  assign byte_ready_o = (state_q == TX_IDLE) ||
                        ((state_q == TX_STOP) && bit_end_s && (bit_idx_q == STOP_LAST));
  assign pop_s  = byte_valid_i && byte_ready_o;
  assign txd_o  = txd_q;
  assign busy_o = (state_q != TX_IDLE);

  // TX FSM: bit timer, bit index, shift register and registered txd.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= TX_IDLE;
      timer_q   <= TW'(0);
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          timer_q   <= TW'(0);
          bit_idx_q <= 3'd0;
          if (pop_s) begin
            shift_q <= byte_data_i;
            txd_q   <= 1'b0;
            state_q <= TX_START;
          end else begin
            txd_q   <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end_s) begin
            timer_q   <= TW'(0);
            bit_idx_q <= 3'd0;
            txd_q     <= shift_q[0];
            state_q   <= TX_DATA;
          end else begin
            timer_q   <= timer_q + TW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end_s) begin
            timer_q <= TW'(0);
            if (bit_idx_q == DATA_LAST) begin
              bit_idx_q <= 3'd0;
              txd_q     <= 1'b1;
              state_q   <= TX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end_s) begin
            timer_q <= TW'(0);
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= 3'd0;
              if (pop_s) begin
                shift_q <= byte_data_i;
                txd_q   <= 1'b0;
                state_q <= TX_START;
              end else begin
                txd_q   <= 1'b1;
                state_q <= TX_IDLE;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q   <= TX_IDLE;
          timer_q   <= TW'(0);
          bit_idx_q <= 3'd0;
          txd_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: core-facing UART transmit stage.
// Accepts 1-byte / 4-byte commands, unpacks words LSB byte first into a byte
// FIFO, and feeds the FIFO to an 8N1 serializer.
// Ports:
//   clk, rstn      core clock, async active-low reset
//   send_data      payload from core
//   core_sig       2'b10 push byte, 2'b11 push word, else no-op
//   flush          synchronous clear of FIFO and unpacker
//   txd            UART serial output, idle high
//   output_stall   core must hold its command while high
//   fifo_count     bytes queued (excludes the byte being transmitted)
//   tx_busy        frame in progress or FIFO non-empty
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 1042,
  parameter int DEPTH_LOG2       = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         send_data,
  input  logic [1:0]          core_sig,
  input  logic                flush,
  output logic                txd,
  output logic                output_stall,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    unpack_cnt_q, unpack_cnt_d;
  logic [23:0]   unpack_data_q, unpack_data_d;

  logic [PW-1:0] count_s;
  logic [PW-1:0] free_s;
  logic          unpack_busy_s;
  logic          accept_s;
  logic          push_s;
  logic [7:0]    push_byte_s;
  logic          fifo_valid_s;
  logic [7:0]    fifo_data_s;
  logic          ser_ready_s;
  logic          ser_busy_s;
  logic          pop_s;

  // Extra pointer MSB distinguishes full from empty.
  assign count_s       = wr_ptr_q - rd_ptr_q;
  assign free_s        = PW'(DEPTH) - count_s;
  assign unpack_busy_s = (unpack_cnt_q != 2'd0);

  // Stall depends only on registered state; 4 free slots guarantee a whole word fits.
  assign output_stall  = unpack_busy_s || (free_s < PW'(4));
  assign accept_s      = is_push_cmd(core_sig) && !output_stall && !flush;

  // A flush discards the queue, so the serializer must not take the head byte that cycle.
  assign fifo_valid_s  = (count_s != PW'(0)) && !flush;
  assign fifo_data_s   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign pop_s         = fifo_valid_s && ser_ready_s;

  assign fifo_count    = count_s;
  assign tx_busy       = ser_busy_s || (count_s != PW'(0));

  // Next-state for FIFO pointers and the word unpacker.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    unpack_cnt_d  = unpack_cnt_q;
    unpack_data_d = unpack_data_q;
    push_s        = 1'b0;
    push_byte_s   = send_data[7:0];
    if (flush) begin
      wr_ptr_d      = PW'(0);
      rd_ptr_d      = PW'(0);
      unpack_cnt_d  = 2'd0;
      unpack_data_d = 24'h000000;
    end else begin
      if (unpack_busy_s) begin
        push_s        = 1'b1;
        push_byte_s   = unpack_data_q[7:0];
        unpack_data_d = {8'h00, unpack_data_q[23:8]};
        unpack_cnt_d  = unpack_cnt_q - 2'd1;
      end else if (accept_s) begin
        push_s      = 1'b1;
        push_byte_s = send_data[7:0];
        if (core_sig == CORE_SIG_WORD) begin
          unpack_data_d = send_data[31:8];
          unpack_cnt_d  = 2'd3;
        end else begin
          unpack_cnt_d  = 2'd0;
        end
      end else begin
        push_s = 1'b0;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer and unpacker registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q      <= PW'(0);
      rd_ptr_q      <= PW'(0);
      unpack_cnt_q  <= 2'd0;
      unpack_data_q <= 24'h000000;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      unpack_cnt_q  <= unpack_cnt_d;
      unpack_data_q <= unpack_data_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_byte_s;
    end
  end

  uart_tx_serializer #(
    .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT)
  ) u_serializer (
    .clk          (clk),
    .rstn         (rstn),
    .byte_valid_i (fifo_valid_s),
    .byte_data_i  (fifo_data_s),
    .byte_ready_o (ser_ready_s),
    .txd_o        (txd),
    .busy_o       (ser_busy_s)
  );

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: randomized self-checking bench for uart_tx_queue.
// Reference model: byte queues plus a frame countdown; expected txd is derived
// from the frame position (start / 8 data bits LSB first / stop).
module tb_uart_tx_queue;

  localparam int H = 4;          // clk cycles per half bit
  localparam int D = 3;          // FIFO depth log2 (8 entries)
  localparam int B = 2 * H;      // cycles per bit
  localparam int F = 10 * B;     // cycles per frame

  logic         clk;
  logic         rstn;
  logic [31:0]  send_data;
  logic [1:0]   core_sig;
  logic         flush;
  logic         txd;
  logic         output_stall;
  logic [D:0]   fifo_count;
  logic         tx_busy;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [7:0] m_fifo [$];
  logic [7:0] m_pend [$];
  int         m_left;
  logic [7:0] m_cur;

  uart_tx_queue #(
    .CLK_PER_HALF_BIT (H),
    .DEPTH_LOG2       (D)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .send_data    (send_data),
    .core_sig     (core_sig),
    .flush        (flush),
    .txd          (txd),
    .output_stall (output_stall),
    .fifo_count   (fifo_count),
    .tx_busy      (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_txd();
    int el;
    int b;
    if (m_left == 0) return 1'b1;
    el = F - m_left;
    b  = el / B;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic m_stall();
    return (m_pend.size() != 0) || (((1 << D) - m_fifo.size()) < 4);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_pend.delete();
    m_left = 0;
    m_cur  = 8'h00;
  endtask

  // One clock edge of the reference model.
  task automatic model_edge(input logic acc, input logic is_word, input logic [31:0] data,
                            input logic fl);
    if (m_left > 0) m_left--;
    if (fl) begin
      m_fifo.delete();
      m_pend.delete();
    end else begin
      if (m_left == 0 && m_fifo.size() != 0) begin
        m_cur  = m_fifo.pop_front();
        m_left = F;
      end
      if (m_pend.size() != 0) begin
        m_fifo.push_back(m_pend.pop_front());
      end else if (acc) begin
        m_fifo.push_back(data[7:0]);
        if (is_word) begin
          m_pend.push_back(data[15:8]);
          m_pend.push_back(data[23:16]);
          m_pend.push_back(data[31:24]);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("txd",   {31'd0, txd},          {31'd0, m_txd()});
    chk("stall", {31'd0, output_stall}, {31'd0, m_stall()});
    chk("count", 32'(fifo_count),       32'(m_fifo.size()));
    chk("busy",  {31'd0, tx_busy},      {31'd0, (m_left != 0) || (m_fifo.size() != 0)});
  endtask

  // Called at a negedge: check, drive, advance one edge, return at next negedge.
  task automatic cycle(input logic [1:0] sig, input logic [31:0] data, input logic fl);
    logic acc;
    check_all();
    core_sig  = sig;
    send_data = data;
    flush     = fl;
    acc = sig[1] && !m_stall() && !fl;
    @(posedge clk);
    model_edge(acc, (sig == 2'b11), data, fl);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, $urandom, 1'b0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rstn      = 1'b0;
    core_sig  = 2'b00;
    send_data = 32'h0;
    flush     = 1'b0;
    model_reset();

    // Reset values
    #12;
    chk("rst_txd",   {31'd0, txd},          32'd1);
    chk("rst_stall", {31'd0, output_stall}, 32'd0);
    chk("rst_count", 32'(fifo_count),       32'd0);
    chk("rst_busy",  {31'd0, tx_busy},      32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(4);

    // Single byte 0xA5
    cycle(2'b10, 32'h000000A5, 1'b0);
    idle(F + 10);

    // Word, bytes go out 44,33,22,11 back-to-back
    cycle(2'b11, 32'h11223344, 1'b0);
    chk("word_stall", {31'd0, output_stall}, 32'd1);
    idle(4 * F + 10);

    // Random commands with backpressure
    for (int i = 0; i < 1200; i++) cycle(2'($urandom_range(0, 3)), $urandom, 1'b0);
    for (int i = 0; i < 20 * F && (m_left != 0 || m_fifo.size() != 0 || m_pend.size() != 0); i++)
      idle(1);
    idle(2);
    chk("drain_busy",  {31'd0, tx_busy}, 32'd0);
    chk("drain_count", 32'(fifo_count),  32'd0);

    // Flush during byte0's DATA phase; command in the flush cycle is dropped
    for (int i = 0; i < 5; i++) cycle(2'b10, $urandom, 1'b0);
    idle(3 * B);
    cycle(2'b10, 32'h0000005A, 1'b1);
    idle(F);
    chk("flush_count", 32'(fifo_count),  32'd0);
    chk("flush_txd",   {31'd0, txd},     32'd1);
    chk("flush_busy",  {31'd0, tx_busy}, 32'd0);

    // Reset during data bit 3
    cycle(2'b10, 32'h000000C3, 1'b0);
    idle(4 * B + B / 2);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_txd",  {31'd0, txd},     32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(F);
    chk("post_rst_txd",  {31'd0, txd},     32'd1);
    chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
